// File: rtl/othello_pkg.sv
// Shared definitions for the Othello move receiver: ASCII codes, FSM encodings
// and small byte-classification helpers.
package othello_pkg;

  localparam logic [7:0] ASCII_A_UC = 8'h41;
  localparam logic [7:0] ASCII_A_LC = 8'h61;
  localparam logic [7:0] ASCII_1    = 8'h31;
  localparam logic [7:0] ASCII_P_UC = 8'h50;
  localparam logic [7:0] ASCII_P_LC = 8'h70;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [1:0] {WAIT_COL, WAIT_ROW, WAIT_EOL} parse_state_e;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  function automatic logic is_eol(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

  // True when b lies in [base, base+7]; relies on unsigned wrap-around.
  function automatic logic in_range8(input logic [7:0] b, input logic [7:0] base);
    logic [7:0] off;
    off = b - base;
    return off < 8'd8;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Bit-level 8N1 receiver: RxD synchronizer, free-running 16x oversample
// divider and byte FSM. Emits a one-cycle strobe or frame_err per byte.
module uart_rx_core
  import othello_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       strobe,
  output logic       frame_err
);

  localparam int DIV   = CLK_FREQ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  rx_state_e        state_q, state_d;
  logic [3:0]       tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             strobe_q, strobe_d, ferr_q, ferr_d;

  assign sync1_d = rxd;
  assign sync2_d = sync1_q;
  assign tick    = (div_q == DIV_LAST);
  assign div_d   = tick ? '0 : div_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    strobe_d   = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!sync2_q) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end
      START: begin
        // Mid-start recheck filters glitches shorter than half a bit.
        if (tick) begin
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = sync2_q ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shift_d   = {sync2_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            state_d  = IDLE;
            strobe_d = sync2_q;
            ferr_d   = !sync2_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      div_q      <= '0;
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      strobe_q   <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      div_q      <= div_d;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      strobe_q   <= strobe_d;
      ferr_q     <= ferr_d;
    end
  end

  assign data      = shift_q;
  assign strobe    = strobe_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/uart_move_rx.sv
// Othello move receiver: parses "<col><row><EOL>" or "P<EOL>" from the UART
// byte stream and presents it through a valid/ack handshake.
module uart_move_rx
  import othello_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       RxD,
  output logic [2:0] move_x,
  output logic [2:0] move_y,
  output logic       move_pass,
  output logic       move_valid,
  input  logic       move_ack,
  output logic       frame_err,
  output logic       cmd_err
);

  logic [7:0]   rx_data;
  logic         rx_strobe;
  parse_state_e pstate_q, pstate_d;
  logic [2:0]   col_q, col_d, row_q, row_d, x_q, x_d, y_q, y_d;
  logic         pass_q, pass_d, mpass_q, mpass_d, valid_q, valid_d, err_q, err_d;
  logic         issue, retire;
  logic [7:0]   uc_off, lc_off, num_off;

  uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_core (
    .clk       (clk),
    .rst       (RST),
    .rxd       (RxD),
    .data      (rx_data),
    .strobe    (rx_strobe),
    .frame_err (frame_err)
  );

  assign uc_off  = rx_data - ASCII_A_UC;
  assign lc_off  = rx_data - ASCII_A_LC;
  assign num_off = rx_data - ASCII_1;
  assign retire  = valid_q && move_ack;

  always_comb begin
    pstate_d = pstate_q;
    col_d    = col_q;
    row_d    = row_q;
    pass_d   = pass_q;
    err_d    = 1'b0;
    issue    = 1'b0;
    if (rx_strobe) begin
      case (pstate_q)
        WAIT_COL: begin
          if (in_range8(rx_data, ASCII_A_UC)) begin
            col_d = uc_off[2:0]; pass_d = 1'b0; pstate_d = WAIT_ROW;
          end else if (in_range8(rx_data, ASCII_A_LC)) begin
            col_d = lc_off[2:0]; pass_d = 1'b0; pstate_d = WAIT_ROW;
          end else if (rx_data == ASCII_P_UC || rx_data == ASCII_P_LC) begin
            pass_d = 1'b1; pstate_d = WAIT_EOL;
          end else if (!is_eol(rx_data)) begin
            err_d = 1'b1;
          end
        end
        WAIT_ROW: begin
          pstate_d = WAIT_COL;
          if (in_range8(rx_data, ASCII_1)) begin
            row_d = num_off[2:0]; pstate_d = WAIT_EOL;
          end else begin
            err_d = 1'b1;
          end
        end
        WAIT_EOL: begin
          pstate_d = WAIT_COL;
          pass_d   = 1'b0;
          if (is_eol(rx_data)) issue = 1'b1;
          else                 err_d = 1'b1;
        end
        default: pstate_d = WAIT_COL;
      endcase
    end
  end

  // A coinciding ack frees the slot, so the new command loads instead of overrunning.
  always_comb begin
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    mpass_d = mpass_q;
    if (issue) begin
      if (!valid_q || retire) begin
        valid_d = 1'b1;
        x_d     = pass_q ? 3'd0 : col_q;
        y_d     = pass_q ? 3'd0 : row_q;
        mpass_d = pass_q;
      end
    end else if (retire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      pstate_q <= WAIT_COL;
      col_q    <= '0;
      row_q    <= '0;
      pass_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      mpass_q  <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      pstate_q <= pstate_d;
      col_q    <= col_d;
      row_q    <= row_d;
      pass_q   <= pass_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mpass_q  <= mpass_d;
      valid_q  <= valid_d;
      err_q    <= err_d || (issue && valid_q && !retire);
    end
  end

  assign move_x     = x_q;
  assign move_y     = y_q;
  assign move_pass  = mpass_q;
  assign move_valid = valid_q;
  assign cmd_err    = err_q;

endmodule

// File: tb/tb_uart_move_rx.sv
// Scoreboard bench for uart_move_rx: stimulus pushes expected moves, a monitor
// pops them on each move_valid rising edge and tracks error pulses.
module tb_uart_move_rx;

  localparam int CLK_FREQ = 7372800;
  localparam int BAUD     = 115200;
  localparam int DIV      = CLK_FREQ / (BAUD * 16);
  localparam int BIT_CYC  = 16 * DIV;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  logic       clk = 1'b0;
  logic       RST, RxD, move_ack;
  logic [2:0] move_x, move_y;
  logic       move_pass, move_valid, frame_err, cmd_err;

  uart_move_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk        (clk),
    .RST        (RST),
    .RxD        (RxD),
    .move_x     (move_x),
    .move_y     (move_y),
    .move_pass  (move_pass),
    .move_valid (move_valid),
    .move_ack   (move_ack),
    .frame_err  (frame_err),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int pass;} move_t;
  move_t exp_q[$];
  move_t mon_e;

  int tests = 0;
  int fails = 0;
  int cmd_err_cnt = 0;
  int frame_err_cnt = 0;
  logic prev_valid = 1'b0, prev_cerr = 1'b0, prev_ferr = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!RST) begin
      if (move_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected move_valid", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("move_x", int'(move_x), mon_e.x);
          check("move_y", int'(move_y), mon_e.y);
          check("move_pass", int'(move_pass), mon_e.pass);
          $display("[TB] move x=%0d y=%0d pass=%0d", move_x, move_y, move_pass);
        end
      end
      if (cmd_err) cmd_err_cnt++;
      if (frame_err) frame_err_cnt++;
      if (prev_cerr) check("cmd_err one-cycle", int'(cmd_err), 0);
      if (prev_ferr) check("frame_err one-cycle", int'(frame_err), 0);
    end
    prev_valid = move_valid;
    prev_cerr  = cmd_err;
    prev_ferr  = frame_err;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    RxD = 1'b0;
    cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      cyc(BIT_CYC);
    end
    if (bad_stop) begin
      // Low across the stop sample point, high again before the start recheck.
      RxD = 1'b0;
      cyc(BIT_CYC * 3 / 4);
      RxD = 1'b1;
      cyc(BIT_CYC / 4);
    end else begin
      RxD = 1'b1;
      cyc(BIT_CYC);
    end
    cyc(BIT_CYC);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!move_valid && n < 4 * BIT_CYC) begin
      @(negedge clk);
      n++;
    end
    check("move_valid within bound", int'(move_valid), 1);
  endtask

  task automatic do_ack();
    @(posedge clk); #1 move_ack = 1'b1;
    @(posedge clk); #1 move_ack = 1'b0;
    @(negedge clk);
    check("move_valid cleared after ack", int'(move_valid), 0);
  endtask

  task automatic push(input int x, input int y, input int p);
    move_t m;
    m.x = x; m.y = y; m.pass = p;
    exp_q.push_back(m);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, f0;
    RST = 1'b1; RxD = 1'b1; move_ack = 1'b0;
    cyc(5);
    @(negedge clk);
    check("reset move_valid", int'(move_valid), 0);
    check("reset move_x", int'(move_x), 0);
    check("reset move_y", int'(move_y), 0);
    check("reset move_pass", int'(move_pass), 0);
    check("reset cmd_err", int'(cmd_err), 0);
    check("reset frame_err", int'(frame_err), 0);
    cyc(1);
    RST = 1'b0;
    cyc(20);
    do_ack();   // ack with nothing pending is ignored

    // "C4\r", held without ack
    push(2, 3, 0);
    send_str("C4"); send_byte(CR, 1'b0);
    wait_valid();
    for (int k = 0; k < 4; k++) begin
      cyc(40);
      @(negedge clk);
      check("hold move_valid", int'(move_valid), 1);
      check("hold move_x", int'(move_x), 2);
      check("hold move_y", int'(move_y), 3);
    end
    do_ack();

    // "p\r\n": pass, trailing LF is harmless
    c0 = cmd_err_cnt;
    push(0, 0, 1);
    send_str("p"); send_byte(CR, 1'b0); send_byte(LF, 1'b0);
    wait_valid();
    check("pass: cmd_err pulses", cmd_err_cnt - c0, 0);
    do_ack();

    // "Z", "A9\r", "h8\r"
    c0 = cmd_err_cnt;
    push(7, 7, 0);
    send_str("Z"); send_str("A9"); send_byte(CR, 1'b0);
    send_str("h8"); send_byte(CR, 1'b0);
    wait_valid();
    check("syntax: cmd_err pulses", cmd_err_cnt - c0, 2);
    do_ack();

    // 0x43 with a low stop bit, then "D5\r"
    c0 = cmd_err_cnt; f0 = frame_err_cnt;
    send_byte(8'h43, 1'b1);
    check("framing: frame_err pulses", frame_err_cnt - f0, 1);
    push(3, 4, 0);
    send_str("D5"); send_byte(CR, 1'b0);
    wait_valid();
    check("framing: cmd_err pulses", cmd_err_cnt - c0, 0);
    do_ack();

    // "A1\r" then "B2\r" without ack: overrun
    push(0, 0, 0);
    send_str("A1"); send_byte(CR, 1'b0);
    wait_valid();
    c0 = cmd_err_cnt;
    send_str("B2"); send_byte(CR, 1'b0);
    @(negedge clk);
    check("overrun: cmd_err pulses", cmd_err_cnt - c0, 1);
    check("overrun: move_valid", int'(move_valid), 1);
    check("overrun: move_x", int'(move_x), 0);
    check("overrun: move_y", int'(move_y), 0);
    do_ack();

    // one-tick glitch, then reset in the middle of 'E'
    c0 = cmd_err_cnt; f0 = frame_err_cnt;
    RxD = 1'b0; cyc(DIV); RxD = 1'b1;
    cyc(3 * BIT_CYC);
    check("glitch: cmd_err pulses", cmd_err_cnt - c0, 0);
    check("glitch: frame_err pulses", frame_err_cnt - f0, 0);
    RxD = 1'b0; cyc(BIT_CYC);
    RxD = 1'b1; cyc(BIT_CYC);
    RxD = 1'b0; cyc(BIT_CYC / 2);
    RST = 1'b1; cyc(3);
    RST = 1'b0; RxD = 1'b1;
    cyc(12 * BIT_CYC);
    check("reset mid-byte: cmd_err pulses", cmd_err_cnt - c0, 0);
    check("reset mid-byte: frame_err pulses", frame_err_cnt - f0, 0);
    check("reset mid-byte: move_valid", int'(move_valid), 0);
    push(5, 5, 0);
    send_str("F6"); send_byte(CR, 1'b0);
    wait_valid();
    do_ack();

    cyc(10);
    check("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_move_rx.md
UART_MOVE_RX -- requirements
Module: uart_move_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; one clock, reset is synchronous and active-high.
REQ-004 The block SHALL have port RST, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port RxD, input, 1 bit: RS232 line from the PC, idle high, asynchronous to clk.
REQ-006 The block SHALL have port move_x, output, 3 bits: column of the received move (0 = 'A').
REQ-007 The block SHALL have port move_y, output, 3 bits: row of the received move (0 = '1').
REQ-008 The block SHALL have port move_pass, output, 1 bit: the received command is a pass.
REQ-009 The block SHALL have port move_valid, output, 1 bit: a command is pending.
REQ-010 The block SHALL have port move_ack, input, 1 bit: the consumer takes the pending command.
REQ-011 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a byte fails its stop bit.
REQ-012 The block SHALL have port cmd_err, output, 1 bit: one-cycle pulse on a syntax error or an overrun.

Function
REQ-013 RxD SHALL pass through a 2-FF synchronizer before any use.
REQ-014 Oversample tick SHALL fire every DIV = CLK_FREQ/(BAUD*16) clk cycles, using integer division (27 at defaults); the divider SHALL run free.
REQ-015 Byte FSM states SHALL be IDLE, START, DATA, STOP; the frame format SHALL be 8N1, LSB first.
REQ-016 IDLE->START SHALL occur on synchronized RxD low; START SHALL recheck at tick 8: low->DATA, high->IDLE (glitch rejected, no error).
REQ-017 DATA SHALL sample each bit at 16 ticks after the previous sample point, which is mid-bit; after bit 7 -> STOP.
REQ-018 STOP SHALL sample at mid-bit: high -> byte strobe (1 cycle) to the parser; low -> frame_err pulse, byte discarded, parser state unchanged; both cases -> IDLE.
REQ-019 Parser states SHALL be WAIT_COL, WAIT_ROW, WAIT_EOL.
REQ-020 WAIT_COL: 'A'-'H' or 'a'-'h' -> latch col-'A' (or col-'a'), go WAIT_ROW; 'P'/'p' -> set pass flag, go WAIT_EOL; CR (0x0D) or LF (0x0A) -> ignored, stay (tolerates CRLF); any other byte -> cmd_err, stay.
REQ-021 WAIT_ROW: '1'-'8' -> latch row-'1', go WAIT_EOL; any other byte -> cmd_err, go WAIT_COL.
REQ-022 WAIT_EOL: CR or LF -> issue the command, go WAIT_COL; any other byte -> cmd_err, clear the pass flag, go WAIT_COL.
REQ-023 Issue SHALL be as follows: if move_valid=0, load move_x/move_y/move_pass and raise move_valid on the next cycle; if move_valid=1, drop the new command and pulse cmd_err (overrun).
REQ-024 move_valid SHALL hold, with move_x/move_y/move_pass stable, until a cycle with move_ack=1; it SHALL clear on the following edge.
REQ-025 On a pass command, move_x and move_y SHALL be 0.
REQ-026 If issue and ack coincide in one cycle while valid=1, the old command SHALL be retired and the new command SHALL be loaded (no overrun).
REQ-027 move_ack while move_valid=0 SHALL be ignored.
REQ-028 Latency from the mid-point of the EOL stop bit to move_valid=1 SHALL be at most 2 clk cycles.

Reset
REQ-029 With RST=1 at a clk edge: byte FSM -> IDLE, parser -> WAIT_COL, divider and bit counters -> 0, move_valid=0, move_x=0, move_y=0, move_pass=0, frame_err=0, cmd_err=0, synchronizer FFs=1.
REQ-030 Reset asserted mid-byte or mid-command SHALL discard the partial data; after release, reception SHALL restart on the next falling edge of RxD.

Structure
REQ-031 ASCII constants (0x41, 0x61, 0x31, 0x50, 0x70, 0x0D, 0x0A) and the parser state encoding SHALL live in the shared othello package.
REQ-032 The bit-level receiver (synchronizer, divider, byte FSM; outputs data[7:0], strobe, frame_err) SHALL be the sub-module uart_rx_core; the parser and handshake SHALL stay in uart_move_rx.

Verification
REQ-033 Bench: "C4\r" at 115200 baud, move_ack held low -> move_valid=1, move_x=2, move_y=3, move_pass=0, stable until move_ack; 1 cycle after move_ack -> move_valid=0.
REQ-034 Bench: "p\r\n" -> move_valid=1, move_pass=1, move_x=0, move_y=0; the trailing LF produces no cmd_err.
REQ-035 Bench: "Z", then "A9\r", then "h8\r" -> cmd_err pulses for 'Z' and '9'; the stray CR after "A9" is ignored; then move_x=7, move_y=7.
REQ-036 Bench: byte 0x43 sent with stop bit driven low -> frame_err one-cycle pulse; following "D5\r" -> move_x=3, move_y=4.
REQ-037 Bench: "A1\r" then "B2\r" with no ack -> second command dropped, cmd_err pulse, outputs remain x=0, y=0.
REQ-038 Bench: 1-tick-wide low glitch on RxD -> no strobe and no error; RST pulsed during the second data bit of 'E', then "F6\r" -> move_x=5, move_y=5.
